// File: rtl/inst_cache_refill.sv
// Instruction cache refill engine: fetches a missing line over AXI, writes the
// data banks and tag/valid RAM, forwards the critical word, optionally prefetches.
//
// state  | meaning
// IDLE   | waiting for a demand miss
// INV    | clear the valid bit of the target line before overwriting it
// ADDR   | present the AR request until accepted
// DATA   | accept R beats, write one bank per beat
// COMMIT | write tag + valid, signal completion, maybe chain into prefetch
module inst_cache_refill #(
    parameter int         LINE_WORDS  = 8,
    parameter int         INDEX_WIDTH = 7,
    parameter int         TAG_WIDTH   = 20,
    parameter logic [3:0] ARID        = 4'd0,
    parameter bit         PREFETCH_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_req,
    input  logic [31:0]            miss_addr,
    input  logic                   pre_found,
    output logic                   refill_busy,
    output logic                   refill_done,
    output logic                   refill_err,
    output logic                   crit_valid,
    output logic [31:0]            crit_data,
    output logic [3:0]             arid,
    output logic [31:0]            araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    output logic [LINE_WORDS-1:0]  data_wen,
    output logic [31:0]            data_wdata,
    output logic [INDEX_WIDTH-1:0] wr_index,
    output logic [TAG_WIDTH-1:0]   tag_wdata,
    output logic                   valid_wdata,
    output logic                   tagv_wen
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int LA_W  = 32 - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INV    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              pf_q, pf_d;
    logic              pf_pending_q, pf_pending_d;
    logic [LA_W-1:0]   line_q, line_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              err_q, err_d;

    logic [INDEX_WIDTH-1:0] line_index;
    logic [TAG_WIDTH-1:0]   line_tag;

    // line address in line units: low bits are the set index, the rest the tag
    assign line_index = line_q[INDEX_WIDTH-1:0];
    assign line_tag   = line_q[INDEX_WIDTH +: TAG_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pf_q         <= 1'b0;
            pf_pending_q <= 1'b0;
            line_q       <= '0;
            offset_q     <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pf_q         <= pf_d;
            pf_pending_q <= pf_pending_d;
            line_q       <= line_d;
            offset_q     <= offset_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pf_d         = pf_q;
        pf_pending_d = pf_pending_q;
        line_d       = line_q;
        offset_d     = offset_q;
        beat_d       = beat_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                pf_d = 1'b0;
                if (miss_req) begin
                    line_d       = miss_addr[31:OFF_W+2];
                    offset_d     = miss_addr[OFF_W+1:2];
                    pf_pending_d = PREFETCH_EN & ~pre_found;
                    err_d        = 1'b0;
                    beat_d       = '0;
                    state_d      = S_INV;
                end
            end
            S_INV: begin
                beat_d  = '0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                if (arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (rvalid) begin
                    err_d = err_q | (rresp != 2'b00);
                    // rlast alone ends the burst; surplus beats pile onto the last bank
                    if (beat_q != LAST_BEAT) beat_d = beat_q + 1'b1;
                    if (rlast) begin
                        beat_d  = '0;
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                if (!pf_q && pf_pending_q) begin
                    line_d       = line_q + 1'b1;
                    pf_d         = 1'b1;
                    pf_pending_d = 1'b0;
                    err_d        = 1'b0;
                    state_d      = S_INV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        refill_busy = (state_q != S_IDLE);
        refill_done = 1'b0;
        refill_err  = 1'b0;
        crit_valid  = 1'b0;
        crit_data   = '0;
        arid        = '0;
        araddr      = '0;
        arlen       = '0;
        arsize      = '0;
        arburst     = '0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        data_wen    = '0;
        data_wdata  = '0;
        wr_index    = '0;
        tag_wdata   = '0;
        valid_wdata = 1'b0;
        tagv_wen    = 1'b0;
        case (state_q)
            S_INV: begin
                tagv_wen = 1'b1;
                wr_index = line_index;
            end
            S_ADDR: begin
                arvalid = 1'b1;
                arid    = ARID;
                araddr  = {line_q, {(OFF_W+2){1'b0}}};
                arlen   = 8'(LINE_WORDS - 1);
                arsize  = 3'b010;
                arburst = 2'b01;
            end
            S_DATA: begin
                rready   = 1'b1;
                wr_index = line_index;
                if (rvalid) begin
                    data_wen   = {{(LINE_WORDS-1){1'b0}}, 1'b1} << beat_q;
                    data_wdata = rdata;
                    if (!pf_q && (beat_q == offset_q)) begin
                        crit_valid = 1'b1;
                        crit_data  = rdata;
                    end
                end
            end
            S_COMMIT: begin
                tagv_wen    = 1'b1;
                wr_index    = line_index;
                tag_wdata   = line_tag;
                valid_wdata = ~err_q;
                refill_done = ~pf_q;
                refill_err  = ~pf_q & err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_inst_cache_refill.sv
// Bench for inst_cache_refill: acts as a configurable AXI read slave and checks
// every cycle of each refill against line addresses and beat data it generated.
module tb_inst_cache_refill;

    localparam int LW = 8;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        pre_found;
    logic        refill_busy, refill_done, refill_err, crit_valid;
    logic [31:0] crit_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [LW-1:0] data_wen;
    logic [31:0] data_wdata;
    logic [6:0]  wr_index;
    logic [19:0] tag_wdata;
    logic        valid_wdata, tagv_wen;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_cache_refill dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_addr(miss_addr), .pre_found(pre_found),
        .refill_busy(refill_busy), .refill_done(refill_done), .refill_err(refill_err),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .data_wen(data_wen), .data_wdata(data_wdata), .wr_index(wr_index),
        .tag_wdata(tag_wdata), .valid_wdata(valid_wdata), .tagv_wen(tagv_wen)
    );

    wire [155:0] all_out = {refill_busy, refill_done, refill_err, crit_valid, crit_data,
                            arid, araddr, arlen, arsize, arburst, arvalid, rready,
                            data_wen, data_wdata, wr_index, tag_wdata, valid_wdata, tagv_wen};

    // miss_req activity while busy must be ignored
    task automatic noise();
        miss_req  = 1'($urandom_range(0, 1));
        miss_addr = $urandom;
        pre_found = 1'($urandom_range(0, 1));
    endtask

    task automatic run_miss(input logic [31:0] addr, input bit pf_i, input int ar_delay,
                            input int gap, input int err_beat, input int extra, input int rst_beat);
        logic [31:0] lines[$];
        logic [31:0] line, d;
        logic [6:0]  idx;
        logic [19:0] tag;
        logic [2:0]  off;
        logic [7:0]  exp_wen;
        int nb, k, idle_left, bank, stall;
        bit hs, err, is_pf, exp_crit;
        lines.push_back(addr & LINE_MASK);
        if (!pf_i) lines.push_back((addr & LINE_MASK) + 32'd32);
        off = addr[4:2];
        nb  = LW + extra;

        @(negedge clk);
        miss_req = 1'b1; miss_addr = addr; pre_found = pf_i;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) begin n_fail++; $display("FAIL idle_pre: got %h exp 0", all_out); end

        foreach (lines[b]) begin
            line  = lines[b];
            idx   = line[11:5];
            tag   = line[31:12];
            is_pf = (b != 0);

            @(negedge clk); noise();
            #1;
            n_checks++;
            if ({refill_busy, tagv_wen, valid_wdata, wr_index, arvalid, refill_done} !==
                {1'b1, 1'b1, 1'b0, idx, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL inv b%0d: got busy%b wen%b v%b idx%h arv%b done%b exp idx%h",
                         b, refill_busy, tagv_wen, valid_wdata, wr_index, arvalid, refill_done, idx);
            end

            hs = 1'b0; stall = 0;
            for (int i = 0; i < 64 && !hs; i++) begin
                @(negedge clk); noise();
                arready = (stall >= ar_delay);
                #1;
                n_checks++;
                if ({refill_busy, arvalid, araddr, arlen, arsize, arburst, arid, rready, tagv_wen} !==
                    {1'b1, 1'b1, line, 8'd7, 3'b010, 2'b01, 4'd0, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL ar b%0d: got arv%b addr%h len%h size%h burst%h id%h exp addr%h",
                             b, arvalid, araddr, arlen, arsize, arburst, arid, line);
                end
                if (arready) hs = 1'b1; else stall++;
            end
            if (!hs) begin
                n_checks++; n_fail++;
                $display("FAIL ar_timeout b%0d: got no handshake exp one", b);
                @(negedge clk); rst = 1'b1; arready = 1'b0;
                @(negedge clk); rst = 1'b0;
                return;
            end

            err = 1'b0; k = 0; idle_left = gap;
            while (k < nb) begin
                @(negedge clk); noise();
                arready = 1'b0;
                if (idle_left > 0) begin
                    idle_left--;
                    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = $urandom;
                    #1;
                    n_checks++;
                    if ({refill_busy, rready, arvalid, data_wen, crit_valid, tagv_wen} !==
                        {1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
                        n_fail++;
                        $display("FAIL gap b%0d k%0d: got rdy%b wen%h crit%b exp rdy1 wen00 crit0",
                                 b, k, rready, data_wen, crit_valid);
                    end
                end else begin
                    d = $urandom;
                    rvalid = 1'b1; rdata = d;
                    rresp  = (k == err_beat && !is_pf) ? 2'b10 : 2'b00;
                    rlast  = (k == nb - 1);
                    if (!is_pf && k == rst_beat) rst = 1'b1;
                    bank     = (k < LW) ? k : LW - 1;
                    exp_wen  = 8'd1 << bank;
                    exp_crit = !is_pf && (bank == int'(off));
                    if (rresp != 2'b00) err = 1'b1;
                    #1;
                    n_checks++;
                    if ({refill_busy, rready, data_wen, data_wdata, wr_index, crit_valid, crit_data, tagv_wen} !==
                        {1'b1, 1'b1, exp_wen, d, idx, exp_crit, (exp_crit ? d : 32'd0), 1'b0}) begin
                        n_fail++;
                        $display("FAIL beat b%0d k%0d: got wen%h wd%h idx%h crit%b cd%h exp wen%h wd%h idx%h crit%b",
                                 b, k, data_wen, data_wdata, wr_index, crit_valid, crit_data,
                                 exp_wen, d, idx, exp_crit);
                    end
                    if (rst) begin
                        @(negedge clk);
                        rst = 1'b0; miss_req = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                        #1;
                        n_checks++;
                        if (all_out !== '0) begin n_fail++; $display("FAIL rst_mid: got %h exp 0", all_out); end
                        return;
                    end
                    k++;
                    idle_left = gap;
                end
            end

            @(negedge clk); noise();
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            #1;
            n_checks++;
            if ({refill_busy, tagv_wen, valid_wdata, tag_wdata, wr_index, refill_done, refill_err, arvalid, data_wen} !==
                {1'b1, 1'b1, ~err, tag, idx, ~is_pf, ~is_pf & err, 1'b0, 8'd0}) begin
                n_fail++;
                $display("FAIL commit b%0d: got wen%b v%b tag%h idx%h done%b err%b exp v%b tag%h idx%h done%b err%b",
                         b, tagv_wen, valid_wdata, tag_wdata, wr_index, refill_done, refill_err,
                         ~err, tag, idx, ~is_pf, ~is_pf & err);
            end
        end

        @(negedge clk); miss_req = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) begin n_fail++; $display("FAIL idle_post: got %h exp 0", all_out); end
        @(negedge clk);
        #1;
        n_checks++;
        if (all_out !== '0) begin n_fail++; $display("FAIL no_extra_ar: got %h exp 0", all_out); end
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_req = 1'b1; miss_addr = $urandom; pre_found = 1'b0;
        arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (all_out !== '0) begin n_fail++; $display("FAIL reset: got %h exp 0", all_out); end
        end
        @(negedge clk); rst = 1'b0; miss_req = 1'b0; arready = 1'b0;
    endtask

    task automatic test_demand_no_prefetch();
        run_miss(32'h1FC0_0024, 1'b1, 0, 0, -1, 0, -1);
    endtask

    task automatic test_demand_with_prefetch();
        run_miss(32'h1FC0_0024, 1'b0, 0, 0, -1, 0, -1);
    endtask

    task automatic test_index_wrap();
        run_miss(32'h0000_0FE0, 1'b0, 0, 0, -1, 0, -1);
    endtask

    task automatic test_stalls();
        run_miss(32'h8000_135C, 1'b1, 5, 2, -1, 0, -1);
        run_miss(32'h4000_2A08, 1'b0, 5, 2, -1, 0, -1);
    endtask

    task automatic test_rresp_error();
        run_miss(32'h1234_5678, 1'b0, 0, 0, 3, 0, -1);
    endtask

    task automatic test_extra_beats();
        run_miss(32'hCAFE_F01C, 1'b1, 1, 0, -1, 2, -1);
    endtask

    task automatic test_reset_mid_burst();
        run_miss(32'h1FC0_0024, 1'b0, 0, 0, -1, 0, 4);
        run_miss(32'h0BAD_0F04, 1'b1, 0, 0, -1, 0, -1);
    endtask

    task automatic test_back_to_back();
        int e;
        for (int i = 0; i < 20; i++) begin
            e = $urandom_range(0, 11);
            run_miss($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom_range(0, 2), (e < 8) ? e : -1, 0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_demand_no_prefetch();
        test_demand_with_prefetch();
        test_index_wrap();
        test_stalls();
        test_rresp_error();
        test_extra_beats();
        test_reset_mid_burst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end

endmodule
